// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage (mem_stage, mem_stage_ctrl).
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 4;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM stage sequencer: IDLE/REQ/RESP FSM plus the optional ack timeout
// (compiled in with `define MEM_TIMEOUT_EN).
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_op_i,
    input  logic ack_i,
    output logic stall_o,
    output logic req_o,
    output logic bubble_o,
    output logic latch_en_o,
    output logic capture_en_o,
    output logic timeout_o,
    output logic resp_o,
    output logic err_o
);
    import mem_stage_pkg::*;

    state_e state_q, state_d;
    logic   timeout_hit;
    logic   latch_en;
    logic   capture_en;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q counts REQ cycles already spent, so the limit is hit in the
    // TIMEOUT_CYC-th REQ cycle.
    always_comb begin
        timeout_hit = (state_q == ST_REQ) && !ack_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_REQ) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | timeout_hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_i) begin
                    latch_en = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_i || timeout_hit) begin
                    capture_en = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_o      = !rst_i && (((state_q == ST_IDLE) && mem_op_i) || (state_q == ST_REQ));
    assign req_o        = !rst_i && (state_q == ST_REQ);
    assign bubble_o     = stall_o;
    assign latch_en_o   = !rst_i && latch_en;
    assign capture_en_o = !rst_i && capture_en;
    assign timeout_o    = !rst_i && timeout_hit;
    assign resp_o       = !rst_i && (state_q == ST_RESP);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU pass-through, load/store via req/ack data memory port.
// Optional ack timeout enabled with `define MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_write_en_i,
    input  logic              mem_to_reg_i,
    input  logic              mem_write_i,
    input  logic [3:0]        reg_write_addr_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              stall_o,
    output logic              reg_write_en_o,
    output logic              mem_to_reg_o,
    output logic [3:0]        reg_write_addr_o,
    output logic [DATA_W-1:0] alu_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              dmem_err_o
);
    import mem_stage_pkg::*;

    logic mem_op;
    logic is_load;
    logic bubble;
    logic latch_en;
    logic capture_en;
    logic timeout;
    logic resp;

    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rwe_q, rwe_d;
    logic                  m2r_q, m2r_d;
    logic [REG_ADDR_W-1:0] rwa_q, rwa_d;
    logic [DATA_W-1:0]     result_q, result_d;

    // A store flag wins when both are set, so such an op never loads.
    assign mem_op  = mem_to_reg_i | mem_write_i;
    assign is_load = mem_to_reg_i & ~mem_write_i;

    mem_stage_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_op_i     (mem_op),
        .ack_i        (dmem_ack_i),
        .stall_o      (stall_o),
        .req_o        (dmem_req_o),
        .bubble_o     (bubble),
        .latch_en_o   (latch_en),
        .capture_en_o (capture_en),
        .timeout_o    (timeout),
        .resp_o       (resp),
        .err_o        (dmem_err_o)
    );

    always_comb begin
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rwe_d    = rwe_q;
        m2r_d    = m2r_q;
        rwa_d    = rwa_q;
        result_d = result_q;
        if (latch_en) begin
            we_d     = mem_write_i;
            addr_d   = alu_i[ADDR_W-1:0];
            wdata_d  = store_data_i;
            rwe_d    = reg_write_en_i;
            m2r_d    = is_load;
            rwa_d    = reg_write_addr_i;
            result_d = alu_i;
        end else if (capture_en && m2r_q) begin
            result_d = timeout ? DATA_W'(TIMEOUT_DATA) : dmem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rwe_q    <= 1'b0;
            m2r_q    <= 1'b0;
            rwa_q    <= '0;
            result_q <= '0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rwe_q    <= rwe_d;
            m2r_q    <= m2r_d;
            rwa_q    <= rwa_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        reg_write_en_o   = 1'b0;
        mem_to_reg_o     = 1'b0;
        reg_write_addr_o = '0;
        alu_o            = '0;
        if (rst_i) begin
            reg_write_en_o = 1'b0;
        end else if (resp) begin
            reg_write_en_o   = rwe_q;
            mem_to_reg_o     = m2r_q;
            reg_write_addr_o = rwa_q;
            alu_o            = result_q;
        end else if (!bubble) begin
            reg_write_en_o   = reg_write_en_i;
            mem_to_reg_o     = mem_to_reg_i;
            reg_write_addr_o = reg_write_addr_i;
            alu_o            = alu_i;
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (timeout case needs MEM_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reg_write_en_i;
    logic        mem_to_reg_i;
    logic        mem_write_i;
    logic [3:0]  reg_write_addr_i;
    logic [15:0] alu_i;
    logic [15:0] store_data_i;
    logic        stall_o;
    logic        reg_write_en_o;
    logic        mem_to_reg_o;
    logic [3:0]  reg_write_addr_o;
    logic [15:0] alu_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [15:0] dmem_rdata_i;
    logic        dmem_err_o;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;

    always #5 clk_i = ~clk_i;

    mem_stage #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .reg_write_en_i   (reg_write_en_i),
        .mem_to_reg_i     (mem_to_reg_i),
        .mem_write_i      (mem_write_i),
        .reg_write_addr_i (reg_write_addr_i),
        .alu_i            (alu_i),
        .store_data_i     (store_data_i),
        .stall_o          (stall_o),
        .reg_write_en_o   (reg_write_en_o),
        .mem_to_reg_o     (mem_to_reg_o),
        .reg_write_addr_o (reg_write_addr_o),
        .alu_o            (alu_o),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_ack_i       (dmem_ack_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .dmem_err_o       (dmem_err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_nop();
        reg_write_en_i   = 1'b0;
        mem_to_reg_i     = 1'b0;
        mem_write_i      = 1'b0;
        reg_write_addr_i = 4'd0;
        alu_i            = 16'h0000;
        store_data_i     = 16'h0000;
    endtask

    task automatic drive_load(input logic [3:0] rd, input logic [15:0] addr);
        reg_write_en_i   = 1'b1;
        mem_to_reg_i     = 1'b1;
        mem_write_i      = 1'b0;
        reg_write_addr_i = rd;
        alu_i            = addr;
        store_data_i     = 16'h0000;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 16'h0000;
        drive_load(4'd1, 16'h0077);
        #1;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else pass_cnt++;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL rst_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
        total_cnt++; if (mem_to_reg_o !== 1'b0) $display("FAIL rst_m2r: got %b want 0", mem_to_reg_o); else pass_cnt++;
        tick();
        drive_nop();
        rst_i = 1'b0;
        #1;
        total_cnt++; if (dmem_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", dmem_err_o); else pass_cnt++;
        total_cnt++; if (dmem_addr_o !== 16'h0000) $display("FAIL rst_addr: got %h want 0000", dmem_addr_o); else pass_cnt++;
    endtask

    task automatic test_alu();
        reg_write_en_i = 1'b1; reg_write_addr_i = 4'd3; alu_i = 16'h1234;
        #1;
        total_cnt++; if (reg_write_en_o !== 1'b1) $display("FAIL alu_rwe: got %b want 1", reg_write_en_o); else pass_cnt++;
        total_cnt++; if (mem_to_reg_o !== 1'b0) $display("FAIL alu_m2r: got %b want 0", mem_to_reg_o); else pass_cnt++;
        total_cnt++; if (reg_write_addr_o !== 4'd3) $display("FAIL alu_rwa: got %0d want 3", reg_write_addr_o); else pass_cnt++;
        total_cnt++; if (alu_o !== 16'h1234) $display("FAIL alu_val: got %h want 1234", alu_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall_o); else pass_cnt++;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL alu_req: got %b want 0", dmem_req_o); else pass_cnt++;
        tick();
        drive_nop();
    endtask

    task automatic test_load();
        drive_load(4'd5, 16'h0040);
        #1;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL ld_stall0: got %b want 1", stall_o); else pass_cnt++;
        total_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL ld_bubble_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
        total_cnt++; if (alu_o !== 16'h0000) $display("FAIL ld_bubble_alu: got %h want 0000", alu_o); else pass_cnt++;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL ld_req0: got %b want 0", dmem_req_o); else pass_cnt++;
        tick();
        total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL ld_req1: got %b want 1", dmem_req_o); else pass_cnt++;
        total_cnt++; if (dmem_addr_o !== 16'h0040) $display("FAIL ld_addr1: got %h want 0040", dmem_addr_o); else pass_cnt++;
        total_cnt++; if (dmem_we_o !== 1'b0) $display("FAIL ld_we1: got %b want 0", dmem_we_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL ld_stall1: got %b want 1", stall_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'hBEEF;
        #1;
        total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL ld_req2: got %b want 1", dmem_req_o); else pass_cnt++;
        total_cnt++; if (dmem_addr_o !== 16'h0040) $display("FAIL ld_addr2: got %h want 0040", dmem_addr_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL ld_stall2: got %b want 1", stall_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0000;
        drive_nop();
        #1;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL ld_resp_stall: got %b want 0", stall_o); else pass_cnt++;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL ld_resp_req: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (reg_write_en_o !== 1'b1) $display("FAIL ld_resp_rwe: got %b want 1", reg_write_en_o); else pass_cnt++;
        total_cnt++; if (mem_to_reg_o !== 1'b1) $display("FAIL ld_resp_m2r: got %b want 1", mem_to_reg_o); else pass_cnt++;
        total_cnt++; if (reg_write_addr_o !== 4'd5) $display("FAIL ld_resp_rwa: got %0d want 5", reg_write_addr_o); else pass_cnt++;
        total_cnt++; if (alu_o !== 16'hBEEF) $display("FAIL ld_resp_alu: got %h want BEEF", alu_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_store();
        mem_write_i = 1'b1; alu_i = 16'h0010; store_data_i = 16'h00AA; reg_write_addr_i = 4'd2;
        #1;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL st_stall0: got %b want 1", stall_o); else pass_cnt++;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL st_req0: got %b want 0", dmem_req_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b1;
        #1;
        total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL st_req1: got %b want 1", dmem_req_o); else pass_cnt++;
        total_cnt++; if (dmem_we_o !== 1'b1) $display("FAIL st_we: got %b want 1", dmem_we_o); else pass_cnt++;
        total_cnt++; if (dmem_addr_o !== 16'h0010) $display("FAIL st_addr: got %h want 0010", dmem_addr_o); else pass_cnt++;
        total_cnt++; if (dmem_wdata_o !== 16'h00AA) $display("FAIL st_wdata: got %h want 00AA", dmem_wdata_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL st_stall1: got %b want 1", stall_o); else pass_cnt++;
        total_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL st_rwe1: got %b want 0", reg_write_en_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b0;
        drive_nop();
        #1;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL st_resp_stall: got %b want 0", stall_o); else pass_cnt++;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL st_resp_req: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL st_resp_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
        total_cnt++; if (mem_to_reg_o !== 1'b0) $display("FAIL st_resp_m2r: got %b want 0", mem_to_reg_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        drive_load(4'd5, 16'h0100);
        tick();
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h1111;
        #1;
        total_cnt++; if (dmem_addr_o !== 16'h0100) $display("FAIL b2b_addr_a: got %h want 0100", dmem_addr_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b0;
        drive_load(4'd6, 16'h0200);
        #1;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL b2b_gap_resp: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL b2b_resp_stall: got %b want 0", stall_o); else pass_cnt++;
        total_cnt++; if (reg_write_addr_o !== 4'd5) $display("FAIL b2b_rwa_a: got %0d want 5", reg_write_addr_o); else pass_cnt++;
        total_cnt++; if (alu_o !== 16'h1111) $display("FAIL b2b_alu_a: got %h want 1111", alu_o); else pass_cnt++;
        tick();
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL b2b_gap_idle: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL b2b_idle_stall: got %b want 1", stall_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h2222;
        #1;
        total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL b2b_req_b: got %b want 1", dmem_req_o); else pass_cnt++;
        total_cnt++; if (dmem_addr_o !== 16'h0200) $display("FAIL b2b_addr_b: got %h want 0200", dmem_addr_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b0;
        drive_nop();
        #1;
        total_cnt++; if (reg_write_addr_o !== 4'd6) $display("FAIL b2b_rwa_b: got %0d want 6", reg_write_addr_o); else pass_cnt++;
        total_cnt++; if (alu_o !== 16'h2222) $display("FAIL b2b_alu_b: got %h want 2222", alu_o); else pass_cnt++;
        total_cnt++; if (mem_to_reg_o !== 1'b1) $display("FAIL b2b_m2r_b: got %b want 1", mem_to_reg_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_req();
        drive_load(4'd7, 16'h0300);
        tick();
        total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL rmid_req1: got %b want 1", dmem_req_o); else pass_cnt++;
        tick();
        dmem_ack_i = 1'b1; dmem_rdata_i = 16'h5555; rst_i = 1'b1;
        #1;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL rmid_req_rst: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL rmid_stall_rst: got %b want 0", stall_o); else pass_cnt++;
        tick();
        rst_i = 1'b0; dmem_ack_i = 1'b0;
        drive_nop();
        #1;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL rmid_req_after: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b0) $display("FAIL rmid_stall_after: got %b want 0", stall_o); else pass_cnt++;
        total_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL rmid_rwe_after: got %b want 0", reg_write_en_o); else pass_cnt++;
        total_cnt++; if (mem_to_reg_o !== 1'b0) $display("FAIL rmid_m2r_after: got %b want 0", mem_to_reg_o); else pass_cnt++;
        total_cnt++; if (dmem_addr_o !== 16'h0000) $display("FAIL rmid_addr_clr: got %h want 0000", dmem_addr_o); else pass_cnt++;
        reg_write_en_i = 1'b1; reg_write_addr_i = 4'd9; alu_i = 16'hABCD;
        #1;
        total_cnt++; if (alu_o !== 16'hABCD) $display("FAIL rmid_idle_alu: got %h want ABCD", alu_o); else pass_cnt++;
        total_cnt++; if (reg_write_addr_o !== 4'd9) $display("FAIL rmid_idle_rwa: got %0d want 9", reg_write_addr_o); else pass_cnt++;
        tick();
        drive_nop();
        tick();
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL rmid_req_idle: got %b want 0", dmem_req_o); else pass_cnt++;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        drive_load(4'd8, 16'h0400);
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL to_req%0d: got %b want 1", i, dmem_req_o); else pass_cnt++;
        end
        tick();
        drive_nop();
        #1;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL to_resp_req: got %b want 0", dmem_req_o); else pass_cnt++;
        total_cnt++; if (alu_o !== 16'hDEAD) $display("FAIL to_resp_alu: got %h want DEAD", alu_o); else pass_cnt++;
        total_cnt++; if (dmem_err_o !== 1'b1) $display("FAIL to_err_set: got %b want 1", dmem_err_o); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (dmem_err_o !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", dmem_err_o); else pass_cnt++;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        total_cnt++; if (dmem_err_o !== 1'b0) $display("FAIL to_err_clr: got %b want 0", dmem_err_o); else pass_cnt++;
    endtask
`else
    task automatic test_no_timeout();
        drive_load(4'd8, 16'h0400);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        total_cnt++; if (dmem_req_o !== 1'b1) $display("FAIL nto_req_held: got %b want 1", dmem_req_o); else pass_cnt++;
        total_cnt++; if (stall_o !== 1'b1) $display("FAIL nto_stall_held: got %b want 1", stall_o); else pass_cnt++;
        total_cnt++; if (dmem_err_o !== 1'b0) $display("FAIL nto_err: got %b want 0", dmem_err_o); else pass_cnt++;
        rst_i = 1'b1;
        drive_nop();
        tick();
        rst_i = 1'b0;
        #1;
        total_cnt++; if (dmem_req_o !== 1'b0) $display("FAIL nto_req_drop: got %b want 0", dmem_req_o); else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid_req();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Passes ALU results through. Executes loads and stores against an external data memory using a req/ack handshake.
- Stalls upstream while an access is outstanding and inserts bubbles downstream.
- For loads, the result output carries the load data.

Parameters:
- ADDR_W, 16, data-memory word address width (low ADDR_W bits of alu_i)
- DATA_W, 16, datapath width
- TIMEOUT_CYC, 255, ack wait limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- reg_write_en_i  in  1  instruction writes register file
- mem_to_reg_i  in  1  instruction is a load
- mem_write_i  in  1  instruction is a store
- reg_write_addr_i  in  4  destination register
- alu_i  in  DATA_W  ALU result / effective address
- store_data_i  in  DATA_W  store data
- stall_o  out  1  freeze PC/IF/ID/EX and EX/MEM register
- reg_write_en_o  out  1  to MEM/WB
- mem_to_reg_o  out  1  to MEM/WB
- reg_write_addr_o  out  4  to MEM/WB
- alu_o  out  DATA_W  result to MEM/WB (ALU value or load data)
- dmem_req_o  out  1  access request, held until ack
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_W  word address
- dmem_wdata_o  out  DATA_W  write data
- dmem_ack_i  in  1  access complete; read data valid in same cycle
- dmem_rdata_i  in  DATA_W  read data
- dmem_err_o  out  1  sticky timeout flag (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- The clock and reset ports are clk_i and rst_i. The design has one clock. Reset is synchronous and active-high.
- A memory op is mem_to_reg_i | mem_write_i. If both are set, the op is treated as a store.
- FSM states: IDLE, REQ, RESP.
- IDLE, non-memory op:
  - All outputs to MEM/WB are a combinational pass-through of the inputs.
  - stall_o=0.
- IDLE, memory op:
  - stall_o=1 combinationally.
  - Outputs to MEM/WB form a bubble: reg_write_en_o=0, mem_to_reg_o=0, addr 0, alu_o 0.
  - On the clock edge, latch we, addr (alu_i[ADDR_W-1:0]), wdata, reg_write_en, mem_to_reg, reg_write_addr. Go to REQ.
- REQ:
  - dmem_req_o=1 with the latched we/addr/wdata, all stable until ack.
  - stall_o=1. Outputs are a bubble.
  - On dmem_ack_i=1: capture dmem_rdata_i if load, else keep the latched alu value. Go to RESP.
  - Ack in the first REQ cycle is legal.
- RESP:
  - dmem_req_o=0, stall_o=0.
  - Present the latched controls; alu_o = load data or latched alu value. The stores' reg_write_en comes from the latch (normally 0).
  - Next state is IDLE.
  - The instruction now held on the inputs is processed from the following cycle. Upstream advanced at this edge, so it is a new instruction.
- Minimum memory-op latency: 3 cycles from entry to result at MEM/WB (IDLE, REQ with immediate ack, RESP). Each extra ack wait cycle adds 1.
- Back-to-back memory ops: RESP then IDLE re-detect, so there is no request overlap.
- dmem_ack_i outside REQ is ignored.
- Reset:
  - While rst_i=1: stall_o=0, dmem_req_o=0, and reg_write_en_o and mem_to_reg_o are forced 0.
  - Next state is IDLE and all latches clear to 0.
  - Reset mid-REQ abandons the access; the request drops at the next edge.
  - Reset has priority over ack in the same cycle.
- Registered state reset values: state IDLE, latches 0, dmem_err_o 0.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit-min cycle counter runs in REQ and clears on entry.
  - If it reaches TIMEOUT_CYC without ack: go to RESP with load data forced to 16'hDEAD, set dmem_err_o (sticky until rst_i), and drop dmem_req_o.
- MEM_TIMEOUT_EN undefined: REQ waits indefinitely; dmem_err_o is constant 0 and no counter is generated.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/REQ/RESP)
  - DATA_W and REG_ADDR_W=4
  - the TIMEOUT_DATA=16'hDEAD constant
- One natural sub-module, mem_stage_ctrl: the FSM plus timeout counter, producing stall/req/bubble/capture enables. The datapath latches and muxes stay in mem_stage.

Test Plan:
- ALU op (reg_write_en_i=1, addr 4'd3, alu_i=16'h1234): same-cycle outputs 1/0/3/1234, stall_o=0, dmem_req_o=0.
- Load (mem_to_reg_i=1, alu_i=16'h0040, addr 4'd5), ack after 2 REQ cycles with rdata 16'hBEEF:
  - stall_o=1 for 3 cycles.
  - dmem_addr_o=0040 and we=0 held while dmem_req_o=1.
  - RESP outputs reg_write_en_o=1, mem_to_reg_o=1, addr 5, alu_o=BEEF.
- Store (mem_write_i=1, alu_i=16'h0010, store_data_i=16'h00AA), immediate ack:
  - one request with we=1, addr 0010, wdata 00AA.
  - reg_write_en_o=0 throughout.
  - total stall 2 cycles.
- Load followed directly by a second load: two separate requests with a req-low gap of at least one cycle; both results reach MEM/WB in order.
- rst_i asserted in 2nd REQ cycle with ack also high:
  - next cycle dmem_req_o=0, state IDLE.
  - no result issued; reg_write_en_o=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYC=4, no ack on a load: after 4 REQ cycles go to RESP with alu_o=DEAD; dmem_err_o=1 until reset.
